// File: rtl/ranger_pkg.sv
// Shared types and constants for the ultrasonic ranger.
// Holds the FSM encoding, distance width and default timing.
package ranger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_ECHO,
        ST_MEASURE,
        ST_DONE
    } state_t;

    localparam int DST_W = 12;
    localparam logic [DST_W-1:0] DST_NONE = 12'd4095;
    localparam logic [DST_W-1:0] DST_MAX  = 12'd4094;

    localparam int DEF_CYCLES_PER_MM = 291;
    localparam int DEF_TRIG_CYCLES   = 500;
    localparam int DEF_MEAS_PERIOD   = 3_000_000;
    localparam int DEF_ECHO_TIMEOUT  = 1_500_000;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous inputs.
// Both flops reset to 0 so the output is defined out of reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops resolve metastability on i_d.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo timing, mm output.
// Distance is counted with a mod-CYCLES_PER_MM prescaler, no divider.
module ultrasonic_ranger
    import ranger_pkg::*;
#(
    parameter int CYCLES_PER_MM = DEF_CYCLES_PER_MM,
    parameter int TRIG_CYCLES   = DEF_TRIG_CYCLES,
    parameter int MEAS_PERIOD   = DEF_MEAS_PERIOD,
    parameter int ECHO_TIMEOUT  = DEF_ECHO_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             echo,
    output logic             trig,
    output logic [DST_W-1:0] binary_dst,
    output logic             dst_valid,
    output logic             no_echo
);

    localparam int PER_W = cnt_w(MEAS_PERIOD);
    localparam int TO_W  = cnt_w(ECHO_TIMEOUT);
    localparam int SUB_W = cnt_w(CYCLES_PER_MM);
    localparam int TRG_W = cnt_w(TRIG_CYCLES);

    localparam logic [PER_W-1:0] PER_LAST = PER_W'(MEAS_PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ECHO_TIMEOUT - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CYCLES_PER_MM - 1);
    localparam logic [TRG_W-1:0] TRG_LAST = TRG_W'(TRIG_CYCLES - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [PER_W-1:0] r_period;
    logic [TRG_W-1:0] r_trig_cnt;
    logic [TO_W-1:0]  r_to;
    logic [SUB_W-1:0] r_sub;
    logic [DST_W-1:0] r_mm;
    logic             r_timed_out;

    logic             r_trig;
    logic [DST_W-1:0] r_dst;
    logic             r_valid;
    logic             r_no_echo;

    logic w_echo_s;
    logic w_start;
    logic w_trig_done;
    logic w_to_hit;
    logic w_clear;
    logic w_to_run;
    logic w_hit;
    logic w_timeout;

    sync_2ff u_echo_sync (
        .clk (clk),
        .rst (rst),
        .i_d (echo),
        .o_q (w_echo_s)
    );

    assign w_start     = (r_period == PER_LAST);
    assign w_trig_done = (r_trig_cnt == TRG_LAST);
    assign w_to_hit    = (r_to == TO_LAST);

    // Free-running measurement period; never reset by the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period <= '0;
        end else if (w_start) begin
            r_period <= '0;
        end else begin
            r_period <= r_period + PER_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath strobes; timeout outranks echo fall.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_to_run    = 1'b0;
        w_hit       = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_TRIG;
                end
            end
            ST_TRIG: begin
                w_clear = 1'b1;
                if (w_trig_done) begin
                    w_state_nxt = ST_WAIT_ECHO;
                end
            end
            ST_WAIT_ECHO: begin
                w_to_run = 1'b1;
                w_hit    = w_echo_s;
                if (w_to_hit) begin
                    w_state_nxt = ST_DONE;
                    w_timeout   = 1'b1;
                end else if (w_echo_s) begin
                    w_state_nxt = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                w_to_run = 1'b1;
                w_hit    = w_echo_s;
                if (w_to_hit) begin
                    w_state_nxt = ST_DONE;
                    w_timeout   = 1'b1;
                end else if (!w_echo_s) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Trigger pulse length counter, idle at zero outside TRIG.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig_cnt <= '0;
        end else if (r_state == ST_TRIG && !w_trig_done) begin
            r_trig_cnt <= r_trig_cnt + TRG_W'(1);
        end else begin
            r_trig_cnt <= '0;
        end
    end

    // Timeout counter runs across WAIT_ECHO and MEASURE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to <= '0;
        end else if (w_clear) begin
            r_to <= '0;
        end else if (w_to_run) begin
            r_to <= r_to + TO_W'(1);
        end
    end

    // Prescaled echo-high counter: one mm every CYCLES_PER_MM cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sub <= '0;
            r_mm  <= '0;
        end else if (w_clear) begin
            r_sub <= '0;
            r_mm  <= '0;
        end else if (w_hit) begin
            if (r_sub == SUB_LAST) begin
                r_sub <= '0;
                if (r_mm != DST_MAX) begin
                    r_mm <= r_mm + DST_W'(1);
                end
            end else begin
                r_sub <= r_sub + SUB_W'(1);
            end
        end
    end

    // Remember whether this measurement ended by timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timed_out <= 1'b0;
        end else if (w_clear) begin
            r_timed_out <= 1'b0;
        end else if (w_timeout) begin
            r_timed_out <= 1'b1;
        end
    end

    // Registered pin and result outputs; result loads in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig    <= 1'b0;
            r_valid   <= 1'b0;
            r_dst     <= DST_NONE;
            r_no_echo <= 1'b1;
        end else begin
            r_trig  <= (r_state == ST_TRIG);
            r_valid <= (r_state == ST_DONE);
            if (r_state == ST_DONE) begin
                r_dst     <= r_timed_out ? DST_NONE : r_mm;
                r_no_echo <= r_timed_out;
            end
        end
    end

    assign trig       = r_trig;
    assign binary_dst = r_dst;
    assign dst_valid  = r_valid;
    assign no_echo    = r_no_echo;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with shortened period/timeout.
// Pin-level timing: echo edges to dst_valid, trigger spacing, results.
module tb_ultrasonic_ranger;

    localparam int CPM = 291;
    localparam int TC  = 500;
    localparam int MP  = 400_000;
    localparam int ET  = 300_000;

    logic        clk = 1'b0;
    logic        rst;
    logic        echo;
    logic        trig;
    logic [11:0] binary_dst;
    logic        dst_valid;
    logic        no_echo;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nvalid = 0;
    int rel_cyc = 0;
    int rise_cyc = 0;
    int fall_cyc = 0;
    int prev_rise = 0;

    ultrasonic_ranger #(
        .CYCLES_PER_MM (CPM),
        .TRIG_CYCLES   (TC),
        .MEAS_PERIOD   (MP),
        .ECHO_TIMEOUT  (ET)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .echo       (echo),
        .trig       (trig),
        .binary_dst (binary_dst),
        .dst_valid  (dst_valid),
        .no_echo    (no_echo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (dst_valid === 1'b1) nvalid <= nvalid + 1;

    task automatic wait_trig(input logic lvl, input int limit,
                             output bit ok);
        int i;
        ok = 1'b0;
        i = 0;
        while (!ok && i < limit) begin
            @(negedge clk);
            i++;
            if (trig === lvl) ok = 1'b1;
        end
    endtask

    task automatic next_trigger(output bit ok);
        bit ok1;
        bit ok2;
        prev_rise = rise_cyc;
        wait_trig(1'b1, MP + 10, ok1);
        rise_cyc = cyc;
        wait_trig(1'b0, TC + 10, ok2);
        fall_cyc = cyc;
        ok = ok1 && ok2;
    endtask

    task automatic wait_valid(input int limit, output bit ok,
                              output int at);
        int i;
        ok = 1'b0;
        at = -1;
        i = 0;
        while (!ok && i < limit) begin
            @(negedge clk);
            i++;
            if (dst_valid === 1'b1) begin
                ok = 1'b1;
                at = cyc;
            end
        end
    endtask

    task automatic pulse_echo(input int n, output int k);
        echo = 1'b1;
        repeat (n) @(negedge clk);
        echo = 1'b0;
        k = cyc;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        echo = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (trig !== 1'b0) begin
            bad++;
            $display("FAIL reset trig: got %b want 0", trig);
        end
        total++;
        if (binary_dst !== 12'd4095) begin
            bad++;
            $display("FAIL reset dst: got %0d want 4095", binary_dst);
        end
        total++;
        if (dst_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset valid: got %b want 0", dst_valid);
        end
        total++;
        if (no_echo !== 1'b1) begin
            bad++;
            $display("FAIL reset no_echo: got %b want 1", no_echo);
        end
        rst = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic test_first_trigger();
        bit ok;
        int hi;
        wait_trig(1'b1, MP + 10, ok);
        rise_cyc = cyc;
        total++;
        if (!ok || rise_cyc - rel_cyc !== MP + 1) begin
            bad++;
            $display("FAIL first_trig: rose %0d cycles after release want %0d",
                     rise_cyc - rel_cyc, MP + 1);
        end
        wait_trig(1'b0, TC + 10, ok);
        fall_cyc = cyc;
        hi = fall_cyc - rise_cyc;
        total++;
        if (!ok || hi !== TC) begin
            bad++;
            $display("FAIL trig_width: got %0d want %0d", hi, TC);
        end
        total++;
        if (binary_dst !== 12'd4095 || no_echo !== 1'b1) begin
            bad++;
            $display("FAIL idle_hold: dst=%0d no_echo=%b want 4095/1",
                     binary_dst, no_echo);
        end
    endtask

    task automatic test_nominal();
        bit ok;
        int k;
        int at;
        next_trigger(ok);
        total++;
        if (!ok || rise_cyc - prev_rise !== MP) begin
            bad++;
            $display("FAIL trig_spacing: got %0d want %0d",
                     rise_cyc - prev_rise, MP);
        end
        pulse_echo(291_000, k);
        wait_valid(20, ok, at);
        total++;
        if (!ok || at - k !== 4) begin
            bad++;
            $display("FAIL nominal_latency: got %0d want 4", at - k);
        end
        total++;
        if (binary_dst !== 12'd1000) begin
            bad++;
            $display("FAIL nominal_dst: got %0d want 1000", binary_dst);
        end
        total++;
        if (no_echo !== 1'b0) begin
            bad++;
            $display("FAIL nominal_no_echo: got %b want 0", no_echo);
        end
        @(negedge clk);
        total++;
        if (dst_valid !== 1'b0) begin
            bad++;
            $display("FAIL nominal_pulse: valid got %b want 0", dst_valid);
        end
    endtask

    task automatic test_boundary(input string name, input int width,
                                 input int exp_mm);
        bit ok;
        int k;
        int at;
        next_trigger(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_trig: got none want trigger", name);
        end
        pulse_echo(width, k);
        wait_valid(20, ok, at);
        total++;
        if (!ok || at - k !== 4) begin
            bad++;
            $display("FAIL %s_latency: got %0d want 4", name, at - k);
        end
        total++;
        if (binary_dst !== 12'(exp_mm) || no_echo !== 1'b0) begin
            bad++;
            $display("FAIL %s_dst: got %0d/%b want %0d/0",
                     name, binary_dst, no_echo, exp_mm);
        end
        @(negedge clk);
        total++;
        if (dst_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_pulse: valid got %b want 0", name, dst_valid);
        end
    endtask

    task automatic test_timeout(input string name, input bit stuck);
        bit ok;
        int at;
        next_trigger(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_trig: got none want trigger", name);
        end
        echo = stuck;
        wait_valid(ET + 20, ok, at);
        echo = 1'b0;
        total++;
        if (!ok || at - fall_cyc !== ET) begin
            bad++;
            $display("FAIL %s_time: got %0d want %0d",
                     name, at - fall_cyc, ET);
        end
        total++;
        if (binary_dst !== 12'd4095 || no_echo !== 1'b1) begin
            bad++;
            $display("FAIL %s_dst: got %0d/%b want 4095/1",
                     name, binary_dst, no_echo);
        end
        @(negedge clk);
        total++;
        if (dst_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_pulse: valid got %b want 0", name, dst_valid);
        end
    endtask

    task automatic test_spurious();
        bit ok1;
        bit ok2;
        bit ok;
        int n0;
        int k;
        int at;
        #1;
        n0 = nvalid;
        repeat (1000) @(negedge clk);
        echo = 1'b1;
        repeat (2000) @(negedge clk);
        echo = 1'b0;
        prev_rise = rise_cyc;
        wait_trig(1'b1, MP, ok1);
        rise_cyc = cyc;
        echo = 1'b1;
        repeat (100) @(negedge clk);
        echo = 1'b0;
        wait_trig(1'b0, TC + 10, ok2);
        fall_cyc = cyc;
        total++;
        if (!ok1 || !ok2 || rise_cyc - prev_rise !== MP) begin
            bad++;
            $display("FAIL spur_trig: spacing %0d want %0d",
                     rise_cyc - prev_rise, MP);
        end
        total++;
        if (fall_cyc - rise_cyc !== TC) begin
            bad++;
            $display("FAIL spur_trig_width: got %0d want %0d",
                     fall_cyc - rise_cyc, TC);
        end
        pulse_echo(58_200, k);
        wait_valid(20, ok, at);
        total++;
        if (!ok || at - k !== 4) begin
            bad++;
            $display("FAIL spur_latency: got %0d want 4", at - k);
        end
        total++;
        if (binary_dst !== 12'd200 || no_echo !== 1'b0) begin
            bad++;
            $display("FAIL spur_dst: got %0d/%b want 200/0",
                     binary_dst, no_echo);
        end
        @(negedge clk);
        #1;
        total++;
        if (nvalid - n0 !== 1) begin
            bad++;
            $display("FAIL spur_count: got %0d pulses want 1", nvalid - n0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n0;
        next_trigger(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rmid_trig: got none want trigger");
        end
        n0 = nvalid;
        echo = 1'b1;
        repeat (1000) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (binary_dst !== 12'd4095 || no_echo !== 1'b1) begin
            bad++;
            $display("FAIL rmid_dst: got %0d/%b want 4095/1",
                     binary_dst, no_echo);
        end
        total++;
        if (trig !== 1'b0 || dst_valid !== 1'b0) begin
            bad++;
            $display("FAIL rmid_ctl: trig=%b valid=%b want 0/0",
                     trig, dst_valid);
        end
        echo = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rel_cyc = cyc;
        wait_trig(1'b1, MP + 10, ok);
        total++;
        if (!ok || cyc - rel_cyc !== MP + 1) begin
            bad++;
            $display("FAIL rmid_next_trig: got %0d want %0d",
                     cyc - rel_cyc, MP + 1);
        end
        #1;
        total++;
        if (nvalid !== n0) begin
            bad++;
            $display("FAIL rmid_valid: got %0d pulses want 0", nvalid - n0);
        end
    endtask

    initial begin
        test_reset();
        test_first_trigger();
        test_nominal();
        test_boundary("w20370", 20_370, 70);
        test_timeout("no_echo", 1'b0);
        test_boundary("w20369", 20_369, 69);
        test_timeout("stuck", 1'b1);
        test_boundary("w290", 290, 0);
        test_spurious();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
